// File: rtl/pll_underclock_seq_pkg.sv
// pll_seq_pkg: shared types and constants for the PLL underclock sequencer.
//  - pll_seq_state_t : sequencer FSM state. S_LOCK_WAIT exists only when
//    PLL_LOCK_WAIT_EN is defined.
//  - PLL_REG_*       : pll_cfg management register addresses.
//  - K_*_DFLT        : default M-counter fractional words (native / ~1% under).
package pll_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MODE,
    S_GAP1,
    S_W_FRAC,
    S_GAP2,
    S_W_START
`ifdef PLL_LOCK_WAIT_EN
    , S_LOCK_WAIT
`endif
  } pll_seq_state_t;

  localparam logic [5:0] PLL_REG_MODE  = 6'd0;
  localparam logic [5:0] PLL_REG_START = 6'd2;
  localparam logic [5:0] PLL_REG_MFRAC = 6'd7;

  localparam logic [31:0] K_NATIVE_DFLT = 32'd3639383488;
  localparam logic [31:0] K_UNDER_DFLT  = 32'd3262113561;

endpackage

// File: rtl/pll_underclock_seq_if.sv
// pll_underclock_seq_if: pll_cfg management write port.
//  mgmt_write       write strobe (master -> slave)
//  mgmt_address     6-bit register address
//  mgmt_writedata   32-bit register data
//  mgmt_waitrequest slave busy; a write is accepted on a cycle with it low
interface pll_underclock_seq_if;
  logic        mgmt_write;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (output mgmt_write, mgmt_address, mgmt_writedata,
                  input  mgmt_waitrequest);
  modport slave  (input  mgmt_write, mgmt_address, mgmt_writedata,
                  output mgmt_waitrequest);
endinterface

// File: rtl/pll_underclock_seq_sync2.sv
// sync2: two-flop synchroniser, async active-low reset.
//  clk, rst_n : clock / reset
//  d          : asynchronous input
//  q1, q2     : first and second stage (q1 exposed so callers can judge stability)
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q1,
  output logic q2
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q1 <= 1'b0;
      q2 <= 1'b0;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end
endmodule

// File: rtl/pll_underclock_seq.sv
// pll_underclock_seq: fractional-PLL reconfiguration sequencer for 60Hz Adjust.
// Debounces the OSD underclock request and writes mode, M-fraction and start
// registers to pll_cfg, with GAP_CYCLES idle cycles between writes.
// Optional macro PLL_LOCK_WAIT_EN: after the start write, hold busy until the
// PLL relocks (locked seen 0 then 1) or LOCK_TMO cycles elapse (sticky lock_timeout).
// Ports:
//  clk_50m        management clock
//  reset          async, active-low
//  underclock_req requested setting, asynchronous
//  locked         PLL locked (used only with PLL_LOCK_WAIT_EN)
//  mgmt           pll_cfg management port (master)
//  busy           sequence in progress
//  underclock_r   setting last applied or being applied
//  lock_timeout   sticky relock timeout flag
module pll_underclock_seq
  import pll_seq_pkg::*;
#(
  parameter logic [31:0] K_NATIVE   = K_NATIVE_DFLT,
  parameter logic [31:0] K_UNDER    = K_UNDER_DFLT,
  parameter int unsigned GAP_CYCLES = 2,
  parameter logic [19:0] LOCK_TMO   = 20'd1000000
) (
  input  logic                        clk_50m,
  input  logic                        reset,
  input  logic                        underclock_req,
  input  logic                        locked,
  pll_underclock_seq_if.master        mgmt,
  output logic                        busy,
  output logic                        underclock_r,
  output logic                        lock_timeout
);
  localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

  pll_seq_state_t state_q, state_d;
  logic [3:0]     gap_q, gap_d;
  logic           ur_d;
  logic           req_s1, req_s2;
  logic           wr;
  logic [5:0]     addr;
  logic [31:0]    data;
  logic           accepted;

  sync2 u_req_sync (.clk(clk_50m), .rst_n(reset), .d(underclock_req), .q1(req_s1), .q2(req_s2));

  assign accepted = !mgmt.mgmt_waitrequest;

`ifdef PLL_LOCK_WAIT_EN
  logic        unused_lk_s1, lk_s2;
  logic [19:0] lk_cnt_q, lk_cnt_d;
  logic        seen_low_q, seen_low_d;
  logic        tmo_q, tmo_d;

  sync2 u_lock_sync (.clk(clk_50m), .rst_n(reset), .d(locked), .q1(unused_lk_s1), .q2(lk_s2));
  assign lock_timeout = tmo_q;
`else
  logic unused_locked;
  localparam logic [19:0] unused_lock_tmo = LOCK_TMO;
  assign unused_locked = locked;
  assign lock_timeout  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    ur_d    = underclock_r;
    wr      = 1'b0;
    addr    = '0;
    data    = '0;
`ifdef PLL_LOCK_WAIT_EN
    lk_cnt_d   = lk_cnt_q;
    seen_low_d = seen_low_q;
    tmo_d      = tmo_q;
`endif
    case (state_q)
      // Only a request that has held for two samples counts; the value is
      // latched here so a mid-sequence toggle cannot mix payloads.
      S_IDLE: if (req_s1 == req_s2 && req_s2 != underclock_r) begin
        ur_d    = req_s2;
        state_d = S_W_MODE;
      end
      S_W_MODE: begin
        wr   = 1'b1;
        addr = PLL_REG_MODE;
        if (accepted) begin
          state_d = S_GAP1;
          gap_d   = '0;
        end
      end
      S_GAP1: if (gap_q == GAP_LAST) state_d = S_W_FRAC;
              else                   gap_d   = gap_q + 4'd1;
      S_W_FRAC: begin
        wr   = 1'b1;
        addr = PLL_REG_MFRAC;
        data = underclock_r ? K_UNDER : K_NATIVE;
        if (accepted) begin
          state_d = S_GAP2;
          gap_d   = '0;
        end
      end
      S_GAP2: if (gap_q == GAP_LAST) state_d = S_W_START;
              else                   gap_d   = gap_q + 4'd1;
      S_W_START: begin
        wr   = 1'b1;
        addr = PLL_REG_START;
        if (accepted) begin
`ifdef PLL_LOCK_WAIT_EN
          state_d    = S_LOCK_WAIT;
          lk_cnt_d   = '0;
          seen_low_d = 1'b0;
`else
          state_d = S_IDLE;
`endif
        end
      end
`ifdef PLL_LOCK_WAIT_EN
      // Relock is a falling then rising edge of the synchronised lock; a lock
      // that never drops is treated as a failed reconfiguration.
      S_LOCK_WAIT: begin
        if (!lk_s2) seen_low_d = 1'b1;
        if (seen_low_q && lk_s2) begin
          state_d = S_IDLE;
        end else if (lk_cnt_q == LOCK_TMO - 20'd1) begin
          tmo_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          lk_cnt_d = lk_cnt_q + 20'd1;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      gap_q        <= '0;
      underclock_r <= 1'b0;
    end else begin
      state_q      <= state_d;
      gap_q        <= gap_d;
      underclock_r <= ur_d;
    end
  end

`ifdef PLL_LOCK_WAIT_EN
  always_ff @(posedge clk_50m or negedge reset) begin
    if (!reset) begin
      lk_cnt_q   <= '0;
      seen_low_q <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      lk_cnt_q   <= lk_cnt_d;
      seen_low_q <= seen_low_d;
      tmo_q      <= tmo_d;
    end
  end
`endif

  // Outputs decode straight from the async-reset state, so reset drops the
  // strobe immediately.
  assign busy                = (state_q != S_IDLE);
  assign mgmt.mgmt_write     = wr;
  assign mgmt.mgmt_address   = addr;
  assign mgmt.mgmt_writedata = data;

endmodule

// File: tb/tb_pll_underclock_seq.sv
// Testbench for pll_underclock_seq: scoreboard of expected accepted writes,
// filled from a request-level model, drained by an independent monitor.
module tb_pll_underclock_seq;
  import pll_seq_pkg::*;

  localparam logic [31:0] KN  = 32'd3639383488;
  localparam logic [31:0] KU  = 32'd3262113561;
  localparam int          GAP = 2;
  localparam int          TMO = 200;
  localparam int          BOUND = 600;

  logic clk_50m = 1'b0;
  logic reset;
  logic underclock_req;
  logic locked;
  logic busy, underclock_r, lock_timeout;

  pll_underclock_seq_if mgmt();

  pll_underclock_seq #(.K_NATIVE(KN), .K_UNDER(KU), .GAP_CYCLES(GAP), .LOCK_TMO(20'(TMO))) dut (
    .clk_50m(clk_50m), .reset(reset), .underclock_req(underclock_req), .locked(locked),
    .mgmt(mgmt), .busy(busy), .underclock_r(underclock_r), .lock_timeout(lock_timeout)
  );

  always #5 clk_50m = ~clk_50m;

  typedef struct { logic [5:0] addr; logic [31:0] data; int gap; } wr_t;
  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  model_ur;
  int  wr_mode = 0;
  bit  wr_force = 0;
  bit  lock_auto = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", name, act, req);
    end
  endtask

  // A change of the held request relative to the last committed target
  // always costs one full three-write set carrying the new target's word.
  task automatic push_seq(input bit v);
    exp_q.push_back('{PLL_REG_MODE,  32'd0,    -1});
    exp_q.push_back('{PLL_REG_MFRAC, v ? KU : KN, GAP});
    exp_q.push_back('{PLL_REG_START, 32'd0,    GAP});
  endtask

  task automatic set_req(input bit v);
    @(posedge clk_50m); #1;
    underclock_req = v;
    if (v != model_ur) begin
      push_seq(v);
      model_ur = v;
    end
  endtask

  task automatic wait_idle(input string name);
    int  n = 0;
    bit  done = 0;
    while (!done && n < BOUND) begin
      @(negedge clk_50m);
      n++;
      done = (busy == 1'b0 && exp_q.size() == 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: timeout busy %0d pending %0d", name, busy, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_wr(input string name, input logic [5:0] a, input bit need_acc);
    int n = 0;
    bit hit = 0;
    while (!hit && n < BOUND) begin
      @(negedge clk_50m);
      n++;
      hit = mgmt.mgmt_write && mgmt.mgmt_address == a && (!need_acc || !mgmt.mgmt_waitrequest);
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL %s: no write to addr %0d within %0d cycles", name, a, BOUND);
    end
  endtask

  initial begin
    mgmt.mgmt_waitrequest = 1'b0;
    forever begin
      @(posedge clk_50m); #1;
      mgmt.mgmt_waitrequest = (wr_mode != 0) ? ($urandom_range(0, 2) == 0) : wr_force;
    end
  end

  initial begin
    locked = 1'b1;
    forever begin
      @(posedge clk_50m); #1;
      locked = lock_auto ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor: every accepted write must be the next expected one; held strobes
  // must keep their payload; no strobe directly after an acceptance.
  initial begin
    bit          prev_acc, prev_hold;
    logic [5:0]  pa;
    logic [31:0] pd;
    int          idle;
    wr_t         e;
    prev_acc = 0; prev_hold = 0; pa = '0; pd = '0; idle = 0;
    forever begin
      @(negedge clk_50m);
      if (!reset) begin
        prev_acc = 0; prev_hold = 0; idle = 0;
      end else if (mgmt.mgmt_write) begin
        chk("strobe_after_accept", 64'(prev_acc), 64'd0);
        if (prev_hold) begin
          chk("hold_addr", mgmt.mgmt_address, pa);
          chk("hold_data", mgmt.mgmt_writedata, pd);
        end
        if (!mgmt.mgmt_waitrequest) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: actual addr %0d data %0d required none",
                     mgmt.mgmt_address, mgmt.mgmt_writedata);
          end else begin
            e = exp_q.pop_front();
            chk("wr_addr", mgmt.mgmt_address, e.addr);
            chk("wr_data", mgmt.mgmt_writedata, e.data);
            if (e.gap >= 0) chk("wr_gap", 64'(idle), 64'(e.gap));
          end
          prev_acc = 1; prev_hold = 0; idle = 0;
        end else begin
          prev_acc = 0; prev_hold = 1;
          pa = mgmt.mgmt_address; pd = mgmt.mgmt_writedata;
        end
      end else begin
        idle++; prev_acc = 0; prev_hold = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    underclock_req = 1'b0;
    model_ur = 1'b0;
    repeat (2) @(negedge clk_50m);
    chk("rst_write", mgmt.mgmt_write, 0);
    chk("rst_addr", mgmt.mgmt_address, 0);
    chk("rst_data", mgmt.mgmt_writedata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ur", underclock_r, 0);
    chk("rst_tmo", lock_timeout, 0);
    @(posedge clk_50m); #1 reset = 1'b1;

    // Request already matches power-up setting: nothing happens.
    repeat (100) @(negedge clk_50m);
    chk("idle_busy", busy, 0);
    chk("idle_ur", underclock_r, 0);

    // 0 -> 1 with no backpressure.
    set_req(1'b1);
    wait_idle("seq_under");
    chk("seq_under_ur", underclock_r, 1);

    // Backpressure on the M-fraction write: held six cycles, accepted once.
    set_req(1'b0);
    wait_wr("bp_mode", PLL_REG_MODE, 1'b1);
    wr_force = 1'b1;
    wait_wr("bp_frac_start", PLL_REG_MFRAC, 1'b0);
    chk("bp_c1_data", mgmt.mgmt_writedata, KN);
    for (int c = 2; c <= 5; c++) begin
      @(negedge clk_50m);
      chk("bp_held_write", mgmt.mgmt_write, 1);
      chk("bp_held_addr", mgmt.mgmt_address, PLL_REG_MFRAC);
    end
    wr_force = 1'b0;
    @(negedge clk_50m);
    chk("bp_c6_write", mgmt.mgmt_write, 1);
    chk("bp_c6_addr", mgmt.mgmt_address, PLL_REG_MFRAC);
    wait_idle("seq_bp");
    chk("seq_bp_ur", underclock_r, 0);

    // Toggle back during the first gap: two complete sets.
    set_req(1'b1);
    wait_wr("tog_mode", PLL_REG_MODE, 1'b1);
    set_req(1'b0);
    wait_idle("seq_toggle");
    chk("seq_toggle_ur", underclock_r, 0);

    // Reset during the M-fraction write, then restart from the mode write.
    set_req(1'b1);
    wait_wr("rst_frac", PLL_REG_MFRAC, 1'b0);
    reset = 1'b0;
    exp_q.delete();
    model_ur = 1'b0;
    #1;
    chk("midrst_write", mgmt.mgmt_write, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_ur", underclock_r, 0);
    repeat (3) @(posedge clk_50m);
    #1 reset = 1'b1;
    push_seq(1'b1);
    model_ur = 1'b1;
    wait_idle("seq_restart");
    chk("seq_restart_ur", underclock_r, 1);

    // Random requests, glitches and backpressure.
    wr_mode = 1;
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk_50m); #1 underclock_req = ~model_ur;
        @(posedge clk_50m); #1 underclock_req = model_ur;
      end
      set_req(1'($urandom_range(0, 1)));
      repeat (4) @(posedge clk_50m);
      wait_idle("rand_seq");
      chk("rand_ur", underclock_r, model_ur);
    end
    wr_mode = 0;
    chk("tmo_clear", lock_timeout, 0);

`ifdef PLL_LOCK_WAIT_EN
    // Lock never drops: busy for TMO cycles, then sticky timeout.
    lock_auto = 1'b0;
    set_req(~model_ur);
    wait_wr("lk_start", PLL_REG_START, 1'b1);
    repeat (TMO - 5) @(negedge clk_50m);
    chk("lk_busy", busy, 1);
    chk("lk_tmo_early", lock_timeout, 0);
    wait_idle("lk_exit");
    chk("lk_tmo", lock_timeout, 1);
`endif

    repeat (10) @(negedge clk_50m);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
